exp1_stimulus_ctrl: RTL
=======================

Name: exp1_stimulus_ctrl

Overview:
Input-conditioning stage that sits directly upstream of the exp1 gate block and drives its taskMode, subtaskMode, a, b and c inputs.
- Synchronizes and debounces the raw board push-buttons and slide switches.
- Turns the buttons into mode toggles.
- Offers an automatic truth-table sweep of {a,b,c}, so every gate row can be shown without touching the switches.

Parameters:
DEBOUNCE_CYCLES, 100000, consecutive stable clock cycles before a debounced level changes (1 ms at 100 MHz); minimum 2.
SWEEP_CYCLES, 50000000, clock cycles per sweep vector (0.5 s at 100 MHz); minimum 2.

Ports:
clk  input  1  system clock, all logic on rising edge.
rstN  input  1  asynchronous active-low reset.
btnTask  input  1  raw push-button; each press toggles taskMode.
btnSubtask  input  1  raw push-button; each press advances subtaskMode.
btnSweep  input  1  raw push-button; each press toggles sweep mode.
swA  input  1  raw slide switch for a.
swB  input  1  raw slide switch for b.
swC  input  1  raw slide switch for c.
taskMode  output  1  to exp1 taskMode.
subtaskMode  output  2  to exp1 subtaskMode.
a  output  1  to exp1 a.
b  output  1  to exp1 b.
c  output  1  to exp1 c.
sweepActive  output  1  high while in SWEEP state (status LED).

Behaviour:
Interface and reset:
- One clock (clk); reset rstN is asynchronous and active-low.
- Reset takes effect immediately, also mid-sweep.
- All outputs, state and counters reset to 0: taskMode=0, subtaskMode=00, a=b=c=0, sweepActive=0, FSM=MANUAL, debounced levels=0.

Synchronizer and debouncer:
- Each raw input passes through a 2-flop synchronizer, then a debouncer.
- If synced != stable: the counter increments. On the DEBOUNCE_CYCLES-th consecutive differing cycle, stable takes the synced value and the counter clears.
- If synced == stable: the counter clears.
- All outputs are registered. Raw change to output change takes DEBOUNCE_CYCLES+3 rising edges.
- A pulse shorter than DEBOUNCE_CYCLES synced cycles never propagates.

Buttons:
- A rising edge of a debounced button gives a one-cycle pulse. Holding a button produces exactly one pulse.
- btnTask pulse: taskMode toggles.
- btnSubtask pulse: subtaskMode increments modulo 4 (11 -> 00).

FSM states MANUAL and SWEEP:
- MANUAL: a,b,c follow debounced swA,swB,swC; sweepActive=0. A btnSweep pulse moves to SWEEP.
- On entry to SWEEP: {a,b,c} is set to 000, the tick counter is set to 0, and sweepActive=1.
- SWEEP operation:
  - The tick counter counts 0..SWEEP_CYCLES-1.
  - At terminal count, {a,b,c} (a = MSB) increments, wrapping 111 -> 000, and the counter wraps.
  - Switches are ignored.
- A btnSweep pulse in SWEEP returns to MANUAL. On that same edge a,b,c load the current debounced switch levels and the tick counter clears.

Simultaneous events:
- Pulses from different buttons in the same cycle are all applied.
- A btnSweep pulse has priority over a tick in the same cycle.

Optional Feature:
Macro EXP1_SWEEP_SUBTASK_EN.
- Defined: in SWEEP, when {a,b,c} wraps 111 -> 000, subtaskMode also increments modulo 4, so one run covers all 4 gates × 8 rows. If a btnSubtask pulse lands in the same cycle, subtaskMode increments by 1 only.
- Undefined: subtaskMode changes only on a btnSubtask pulse.

Decomposition:
Package exp1_pkg:
- enum typedef exp1_state_t {MANUAL, SWEEP}.
- localparam SUBTASK_W=2.
- localparam VEC_W=3.
Sub-module exp1_debounce:
- One per raw input (6 instances).
- Contains the synchronizer, the debounce counter with $clog2(DEBOUNCE_CYCLES) width, the stable level output and the rise-pulse output.
Top level: exp1_stimulus_ctrl holds the FSM, mode registers and sweep counter.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4 and SWEEP_CYCLES=8.
1. Reset: assert rstN=0 with switches high, then release -> all outputs 0; after swA=1 held, a=1 on the 7th edge.
2. Glitch rejection: btnTask high 3 cycles, then low -> taskMode stays 0. Then held high 20 cycles -> taskMode=1 on the 7th edge, with no further toggles.
3. Subtask wrap: 5 clean btnSubtask presses -> subtaskMode 01, 10, 11, 00, 01.
4. Sweep: one btnSweep press -> sweepActive=1, abc=000; then 001 after 8 cycles, continuing to 111 and wrapping to 000. Switch toggles have no effect. With EXP1_SWEEP_SUBTASK_EN defined, subtaskMode 00 -> 01 at that wrap.
5. Sweep exit: btnSweep press while abc=101 and switches=011 -> sweepActive=0 and abc=011 on the same edge.
6. Reset mid-sweep: rstN=0 at abc=110 -> outputs 0 immediately (asynchronous); FSM is in MANUAL after release.

Source files
------------

// File: rtl/exp1_pkg.sv
// Shared types and widths for the exp1 stimulus controller.
package exp1_pkg;

    typedef enum logic [0:0] {
        MANUAL = 1'b0,
        SWEEP  = 1'b1
    } exp1_state_t;

    localparam int SUBTASK_W = 2;
    localparam int VEC_W     = 3;

endpackage

// File: rtl/exp1_debounce.sv
// Two-flop synchronizer plus counting debouncer for one raw board input.
// level_o is the debounced level; rise_o is a one-cycle pulse issued on the
// same edge at which level_o goes from 0 to 1.
module exp1_debounce #(
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_d;
    logic             rise_q;
    logic             rise_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count consecutive cycles where the synced input disagrees with the stable level.
    always_comb begin
        cnt_d    = {CNT_W{1'b0}};
        stable_d = stable_q;
        rise_d   = 1'b0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
                cnt_d    = {CNT_W{1'b0}};
                rise_d   = sync2_q;
            end else begin
                cnt_d    = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = {CNT_W{1'b0}};
        end
    end

    // Synchronizer flops and debounce state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            cnt_q    <= {CNT_W{1'b0}};
        end else begin
            sync1_q  <= raw_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            cnt_q    <= cnt_d;
        end
    end

    assign level_o = stable_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/exp1_stimulus_ctrl.sv
// Input conditioning for the exp1 gate block: debounced buttons drive mode
// toggles, switches drive a/b/c in MANUAL, and SWEEP steps {a,b,c} through
// the whole truth table.
// Optional feature macro: EXP1_SWEEP_SUBTASK_EN -- when defined, the
// 111 -> 000 wrap in SWEEP also advances subtaskMode.
module exp1_stimulus_ctrl
    import exp1_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int SWEEP_CYCLES    = 50000000
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic                 btnTask,
    input  logic                 btnSubtask,
    input  logic                 btnSweep,
    input  logic                 swA,
    input  logic                 swB,
    input  logic                 swC,
    output logic                 taskMode,
    output logic [SUBTASK_W-1:0] subtaskMode,
    output logic                 a,
    output logic                 b,
    output logic                 c,
    output logic                 sweepActive
);

    localparam int TICK_W = (SWEEP_CYCLES > 2) ? $clog2(SWEEP_CYCLES) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SWEEP_CYCLES - 1);

    // Input lane indices into the debouncer bank.
    localparam int I_TASK = 0;
    localparam int I_SUB  = 1;
    localparam int I_SWP  = 2;
    localparam int I_SWA  = 3;
    localparam int I_SWB  = 4;
    localparam int I_SWC  = 5;

    logic [5:0]           raw_s;
    logic [5:0]           level_s;
    logic [5:0]           rise_s;
    logic                 tick_tc_s;
    logic                 wrap_s;
    logic                 sub_inc_s;
    logic [VEC_W-1:0]     sw_vec_s;
    logic                 unused_s;

    exp1_state_t          state_q;
    logic                 task_q;
    logic [SUBTASK_W-1:0] sub_q;
    logic [VEC_W-1:0]     abc_q;
    logic [TICK_W-1:0]    tick_q;
    logic                 active_q;

    assign raw_s = {swC, swB, swA, btnSweep, btnSubtask, btnTask};

    for (genvar gi = 0; gi < 6; gi++) begin : g_deb
        exp1_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk_i  (clk),
            .rst_ni (rstN),
            .raw_i  (raw_s[gi]),
            .level_o(level_s[gi]),
            .rise_o (rise_s[gi])
        );
    end

    // Buttons only use their pulse, switches only use their level.
    assign unused_s = ^{level_s[I_SWP:I_TASK], rise_s[I_SWC:I_SWA]};
    assign sw_vec_s = {level_s[I_SWA], level_s[I_SWB], level_s[I_SWC]};

    // Terminal-count, truth-table wrap and subtask advance decisions.
    always_comb begin
        tick_tc_s = (tick_q == TICK_LAST);
        wrap_s    = 1'b0;
`ifdef EXP1_SWEEP_SUBTASK_EN
        // A sweep-exit pulse outranks the tick, so no wrap is taken then.
        if ((state_q == SWEEP) && !rise_s[I_SWP] && tick_tc_s &&
            (abc_q == {VEC_W{1'b1}})) begin
            wrap_s = 1'b1;
        end else begin
            wrap_s = 1'b0;
        end
`endif
        // Both sources in one cycle still advance by a single step.
        sub_inc_s = rise_s[I_SUB] | wrap_s;
    end

    // Mode registers, MANUAL/SWEEP state machine and sweep tick counter.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q  <= MANUAL;
            task_q   <= 1'b0;
            sub_q    <= {SUBTASK_W{1'b0}};
            abc_q    <= {VEC_W{1'b0}};
            tick_q   <= {TICK_W{1'b0}};
            active_q <= 1'b0;
        end else begin
            if (rise_s[I_TASK]) begin
                task_q <= ~task_q;
            end
            if (sub_inc_s) begin
                sub_q <= sub_q + SUBTASK_W'(1);
            end
            case (state_q)
                MANUAL: begin
                    if (rise_s[I_SWP]) begin
                        state_q  <= SWEEP;
                        abc_q    <= {VEC_W{1'b0}};
                        tick_q   <= {TICK_W{1'b0}};
                        active_q <= 1'b1;
                    end else begin
                        abc_q    <= sw_vec_s;
                        tick_q   <= {TICK_W{1'b0}};
                        active_q <= 1'b0;
                    end
                end
                SWEEP: begin
                    if (rise_s[I_SWP]) begin
                        state_q  <= MANUAL;
                        abc_q    <= sw_vec_s;
                        tick_q   <= {TICK_W{1'b0}};
                        active_q <= 1'b0;
                    end else if (tick_tc_s) begin
                        tick_q   <= {TICK_W{1'b0}};
                        abc_q    <= abc_q + VEC_W'(1);
                    end else begin
                        tick_q   <= tick_q + TICK_W'(1);
                    end
                end
                default: begin
                    state_q  <= MANUAL;
                    abc_q    <= {VEC_W{1'b0}};
                    tick_q   <= {TICK_W{1'b0}};
                    active_q <= 1'b0;
                end
            endcase
        end
    end

    assign taskMode    = task_q;
    assign subtaskMode = sub_q;
    assign a           = abc_q[2];
    assign b           = abc_q[1];
    assign c           = abc_q[0];
    assign sweepActive = active_q;

endmodule
